// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for a first-word-fall-through read port; otherwise read data is registered.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc_s, rd_acc_s;

  assign full         = (count_q == CNT_WIDTH'(FIFO_DEPTH));
  assign empty        = (count_q == CNT_WIDTH'(0));
  assign almost_full  = (count_q >= CNT_WIDTH'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_WIDTH'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A full FIFO refuses writes even when a read frees a slot in the same cycle (and vice versa).
  assign wr_acc_s = wr_en & ~full;
  assign rd_acc_s = rd_en & ~empty;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc_s) begin
      if (wr_ptr_q == ADDR_WIDTH'(FIFO_DEPTH - 1)) begin
        wr_ptr_d = '0;
      end else begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_acc_s) begin
      if (rd_ptr_q == ADDR_WIDTH'(FIFO_DEPTH - 1)) begin
        rd_ptr_d = '0;
      end else begin
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      end
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase

    // A new error event outranks a simultaneous clear.
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end else if (clr_err) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    if (rd_en && empty) begin
      underflow_d = 1'b1;
    end else if (clr_err) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data  = mem_q[rd_ptr_q];
  assign rd_valid = ~empty;
`else
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  // Registered read port: one-cycle latency, data held between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc_s;
      if (rd_acc_s) begin
        rd_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO that combines storage, read/write pointer control, occupancy tracking and status flags in one block. It supports any depth of 2 or more, including non-power-of-two depths, programmable almost-full and almost-empty thresholds, and sticky error flags. Read data is registered by default; a compile-time first-word-fall-through (FWFT) mode is also available. It sits between single-clock producer and consumer stages and replaces separately instantiated memory and controller logic.

## Interface
- DATA_WIDTH, 8, width of each word.
- FIFO_DEPTH, 16, number of words; must be ≥ 2; need not be a power of two.
- AF_LEVEL, FIFO_DEPTH-2, almost_full asserts when count ≥ AF_LEVEL; range 1..FIFO_DEPTH.
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL; range 0..FIFO_DEPTH-1.
- ADDR_WIDTH, $clog2(FIFO_DEPTH), pointer width.
- CNT_WIDTH, $clog2(FIFO_DEPTH+1), count width.
- One clock; reset is asynchronous and active-high.
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- rd_en  in  1  read request (pop).
- clr_err  in  1  clears overflow and underflow.
- rd_data  out  DATA_WIDTH  read word.
- rd_valid  out  1  rd_data qualifier.
- full, empty, almost_full, almost_empty  out  1 each  status flags.
- count  out  CNT_WIDTH  stored words, 0..FIFO_DEPTH.
- overflow, underflow  out  1 each  sticky error flags.

## Operation
- A write is accepted when wr_en=1 and full=0. The word is stored at wr_ptr and wr_ptr advances.
- A read is accepted when rd_en=1 and empty=0. rd_ptr advances.
- Pointers wrap from FIFO_DEPTH-1 to 0 by explicit compare, not by binary overflow.
- Count update:
  - +1 on a write-only cycle.
  - −1 on a read-only cycle.
  - Unchanged when both are accepted in the same cycle.
- When full, a write is rejected even if a read is accepted in the same cycle. The read still proceeds.
- When empty, a read is rejected even if a write is accepted in the same cycle. The write still proceeds.
- Status flags are combinational decodes of the registered count:
  - full = (count == FIFO_DEPTH)
  - empty = (count == 0)
  - almost_full = (count ≥ AF_LEVEL)
  - almost_empty = (count ≤ AE_LEVEL)
- overflow sets on wr_en & full. underflow sets on rd_en & empty.
- Both error flags hold until clr_err=1. If clr_err and a new error event occur in the same cycle, the set wins.
- Rejected operations do not change the memory, the pointers or count.
- Memory contents are not reset.

## Timing
- Reset values: count=0, empty=1, almost_empty=1 (AE_LEVEL ≥ 0), full=0, almost_full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0, both pointers 0.
- Reset mid-operation clears all state asynchronously. Stored data is discarded and rd_valid drops immediately.
- Default (registered) read:
  - rd_data loads mem[rd_ptr] on the edge that accepts the read.
  - rd_valid=1 for exactly the following cycle (1-cycle latency).
  - rd_data holds its value otherwise.
  - Back-to-back reads give one word per cycle.
- Write-to-empty: empty deasserts the cycle after the write edge. The earliest accepted read is in that cycle.
- Flags and count change only on clock edges (or on reset).

## Configuration
- Macro: SYNC_FIFO_FWFT_EN.
- Undefined: registered read as described in Timing.
- Defined (first-word-fall-through):
  - rd_data = mem[rd_ptr] combinationally and rd_valid = ~empty.
  - rd_en acts as an acknowledge that pops the current word.
  - The first word appears in the cycle after the write edge.
  - In FWFT mode, the rd_data reset value is don't-care.

## Test plan
- Reset, then write 0x01..0x10 with DEPTH=16 → full=1 after the 16th edge, count=16, almost_full=1 from count=14. Then read 16 → data 0x01..0x10 in order, empty=1 at the end.
- With DEPTH=5 (non-power-of-two), do 3 writes / 3 reads repeated 4 times → pointers wrap 4→0, data is in order, count never exceeds 5.
- At count=3, assert wr_en and rd_en together for 10 cycles → count stays 3 and output data is correct.
- When full, assert wr_en=1 with data 0xAA → data is not stored and overflow=1. Apply clr_err → overflow=0. Also apply clr_err together with a new overflow → overflow stays 1.
- When empty, assert rd_en → underflow=1, count stays 0 and rd_valid stays 0.
- Assert reset asynchronously in mid-stream at count=7 → all outputs take their reset values before the next edge. A write after release reads back correctly (in both FWFT and registered builds).
